// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
//   Shared types for the branch resolution unit: operand/PC widths, ROB and
//   branch-mask sizes, the branch kind enum, compare-function encodings, the
//   issue packet and result structs, and the ROB age helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package branch_pkg;

   localparam int XLEN      = 32;
   localparam int ROB_SZ    = 32;
   localparam int ROB_IDX_W = $clog2(ROB_SZ);
   localparam int BMASK_W   = 4;

   typedef enum logic [1:0] {
      COND = 2'd0,
      JAL  = 2'd1,
      JALR = 2'd2
   } BR_KIND;

   localparam logic [2:0] F_EQ  = 3'b000;
   localparam logic [2:0] F_NE  = 3'b001;
   localparam logic [2:0] F_LT  = 3'b100;
   localparam logic [2:0] F_GE  = 3'b101;
   localparam logic [2:0] F_LTU = 3'b110;
   localparam logic [2:0] F_GEU = 3'b111;

   typedef struct packed {
      logic [XLEN-1:0]      rs1;
      logic [XLEN-1:0]      rs2;
      logic [2:0]           func;
      BR_KIND               kind;
      logic [XLEN-1:0]      pc;
      logic [XLEN-1:0]      imm;
      logic                 pred_taken;
      logic [XLEN-1:0]      pred_target;
      logic [ROB_IDX_W-1:0] rob_idx;
      logic [BMASK_W-1:0]   bmask;
   } BR_PKT;

   typedef struct packed {
      logic                 taken;
      logic [XLEN-1:0]      target;
      logic [XLEN-1:0]      link;
      logic                 mispredict;
      logic [ROB_IDX_W-1:0] rob_idx;
   } BR_RES;

   // Distance from the ROB head; ROB_SZ is a power of two so the natural
   // wrap of the subtraction is the modulo.
   function automatic logic [ROB_IDX_W-1:0] rob_age(
      input logic [ROB_IDX_W-1:0] idx,
      input logic [ROB_IDX_W-1:0] head
   );
      return idx - head;
   endfunction

endpackage

// File: rtl/branch_lane.sv
// -----------------------------------------------------------------------------
// branch_lane
//   One branch lane: S1 captures the issue packet, S1 logic resolves
//   direction/target/link/mispredict, S2 holds the result for the consumer.
//   Ports:
//     clock, reset_n      clock and async active-low reset
//     i_advance           whole pipe moves this cycle (no stall)
//     i_in_valid          packet on i_pkt is accepted this cycle
//     i_pkt               issue packet
//     i_squash_valid      squash request this cycle
//     i_squash_tag        one-hot branch tag being squashed
//     o_out_valid         S2 holds a live result (squash already applied)
//     o_res               S2 result
// -----------------------------------------------------------------------------
module branch_lane
   import branch_pkg::*;
(
   input  logic               clock,
   input  logic               reset_n,
   input  logic               i_advance,
   input  logic               i_in_valid,
   input  BR_PKT              i_pkt,
   input  logic               i_squash_valid,
   input  logic [BMASK_W-1:0] i_squash_tag,
   output logic               o_out_valid,
   output BR_RES              o_res
);

   logic               r_s1_vld;
   BR_PKT              r_s1_pkt;
   logic               r_s2_vld;
   BR_RES              r_s2_res;
   logic [BMASK_W-1:0] r_s2_bmask;

   logic            w_in_kill;
   logic            w_s1_kill;
   logic            w_s2_kill;
   logic            w_eq;
   logic            w_lt;
   logic            w_ltu;
   logic            w_cond;
   logic            w_taken;
   logic [XLEN-1:0] w_pc4;
   logic [XLEN-1:0] w_pc_imm;
   logic [XLEN-1:0] w_rs1_imm;
   BR_RES           w_res;

   assign w_in_kill = i_squash_valid & (|(i_pkt.bmask & i_squash_tag));
   assign w_s1_kill = i_squash_valid & (|(r_s1_pkt.bmask & i_squash_tag));
   assign w_s2_kill = i_squash_valid & (|(r_s2_bmask & i_squash_tag));

   assign w_eq      = (r_s1_pkt.rs1 == r_s1_pkt.rs2);
   assign w_lt      = ($signed(r_s1_pkt.rs1) < $signed(r_s1_pkt.rs2));
   assign w_ltu     = (r_s1_pkt.rs1 < r_s1_pkt.rs2);
   assign w_pc4     = r_s1_pkt.pc + XLEN'(4);
   assign w_pc_imm  = r_s1_pkt.pc + r_s1_pkt.imm;
   assign w_rs1_imm = r_s1_pkt.rs1 + r_s1_pkt.imm;

   always_comb begin
      w_cond = 1'b0;
      case (r_s1_pkt.func)
         F_EQ:    w_cond = w_eq;
         F_NE:    w_cond = ~w_eq;
         F_LT:    w_cond = w_lt;
         F_GE:    w_cond = ~w_lt;
         F_LTU:   w_cond = w_ltu;
         F_GEU:   w_cond = ~w_ltu;
         default: w_cond = 1'b0;   // reserved encodings resolve not-taken
      endcase
   end

   // Jumps are unconditional; only COND consults the compare result.
   assign w_taken = (r_s1_pkt.kind == COND) ? w_cond : 1'b1;

   always_comb begin
      w_res         = '0;
      w_res.taken   = w_taken;
      w_res.link    = w_pc4;
      w_res.rob_idx = r_s1_pkt.rob_idx;
      if (r_s1_pkt.kind == JALR)
         w_res.target = w_rs1_imm & ~XLEN'(1);
      else
         w_res.target = w_taken ? w_pc_imm : w_pc4;
      w_res.mispredict = (w_taken != r_s1_pkt.pred_taken) |
                         (w_taken & (w_res.target != r_s1_pkt.pred_target));
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_s1_vld   <= 1'b0;
         r_s1_pkt   <= '0;
         r_s2_vld   <= 1'b0;
         r_s2_res   <= '0;
         r_s2_bmask <= '0;
      end else if (i_advance) begin
         // S0 -> S1: capture issue packet
         r_s1_vld   <= i_in_valid & ~w_in_kill;
         r_s1_pkt   <= i_pkt;
         // S1 -> S2: capture resolved result
         r_s2_vld   <= r_s1_vld & ~w_s1_kill;
         r_s2_res   <= w_res;
         r_s2_bmask <= r_s1_pkt.bmask;
      end else begin
         // Stalled: contents hold, but squash still removes entries.
         r_s1_vld   <= r_s1_vld & ~w_s1_kill;
         r_s2_vld   <= r_s2_vld & ~w_s2_kill;
      end
   end

   assign o_out_valid = r_s2_vld & ~w_s2_kill;
   assign o_res       = r_s2_res;

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//   Multi-lane 2-stage branch resolution. Lanes advance in lock-step; the top
//   generates the stall/ready handshake, fans the squash out to every lane and
//   picks the oldest mispredicting output lane relative to the ROB head.
//   Ports:
//     clock, reset_n   clock and async active-low reset
//     in_valid         per-lane issue valid
//     in_ready         unit accepts issue this cycle
//     in_pkt           per-lane issue packet
//     rob_head         current ROB head for the age compare
//     squash_valid     kill entries whose bmask hits squash_tag
//     squash_tag       one-hot branch tag being squashed
//     out_valid        per-lane result valid
//     out_ready        consumer accepts all lanes
//     out_res          per-lane result
//     mp_valid         some valid output lane mispredicts
//     mp_lane          oldest mispredicting lane
// -----------------------------------------------------------------------------
module branch_resolve_unit
   import branch_pkg::*;
#(
   parameter int NUM_LANES = 2,
   localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
)(
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [NUM_LANES-1:0] in_valid,
   output logic                 in_ready,
   input  BR_PKT [NUM_LANES-1:0] in_pkt,
   input  logic [ROB_IDX_W-1:0] rob_head,
   input  logic                 squash_valid,
   input  logic [BMASK_W-1:0]   squash_tag,
   output logic [NUM_LANES-1:0] out_valid,
   input  logic                 out_ready,
   output BR_RES [NUM_LANES-1:0] out_res,
   output logic                 mp_valid,
   output logic [LANE_W-1:0]    mp_lane
);

   logic [NUM_LANES-1:0] w_out_valid;
   BR_RES [NUM_LANES-1:0] w_res;
   logic                 w_stall;
   logic [ROB_IDX_W-1:0] w_age [NUM_LANES];
   logic                 w_mp_valid;
   logic [LANE_W-1:0]    w_mp_lane;
   logic [ROB_IDX_W-1:0] w_best_age;

   assign w_stall  = (|w_out_valid) & ~out_ready;
   assign in_ready = ~w_stall;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      branch_lane u_lane (
         .clock          (clock),
         .reset_n        (reset_n),
         .i_advance      (~w_stall),
         .i_in_valid     (in_valid[g] & ~w_stall),
         .i_pkt          (in_pkt[g]),
         .i_squash_valid (squash_valid),
         .i_squash_tag   (squash_tag),
         .o_out_valid    (w_out_valid[g]),
         .o_res          (w_res[g])
      );
      assign w_age[g] = rob_age(w_res[g].rob_idx, rob_head);
   end

   // Strict less-than keeps the lower lane on an (impossible) age tie.
   always_comb begin
      w_mp_valid = 1'b0;
      w_mp_lane  = '0;
      w_best_age = '1;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (w_out_valid[i] && w_res[i].mispredict &&
             (!w_mp_valid || (w_age[i] < w_best_age))) begin
            w_mp_valid = 1'b1;
            w_mp_lane  = LANE_W'(i);
            w_best_age = w_age[i];
         end
      end
   end

   assign out_valid = w_out_valid;
   assign out_res   = w_res;
   assign mp_valid  = w_mp_valid;
   assign mp_lane   = w_mp_lane;

endmodule
